// File: rtl/mul4_tournament_pkg.sv
// Shared constants and types for the mul4 candidate tournament.
// Test vector, golden products, FSM states, score width.
package mul4_tournament_pkg;

  localparam logic [15:0] VEC_A1 = 16'hFF00;
  localparam logic [15:0] VEC_A0 = 16'hF0F0;
  localparam logic [15:0] VEC_B1 = 16'hCCCC;
  localparam logic [15:0] VEC_B0 = 16'hAAAA;

  localparam logic [15:0] GOLD_3 = 16'h8000;
  localparam logic [15:0] GOLD_2 = 16'h4C00;
  localparam logic [15:0] GOLD_1 = 16'h6AC0;
  localparam logic [15:0] GOLD_0 = 16'hA0A0;

  localparam int SCORE_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    WAIT,
    SCORE,
    DONE
  } state_t;

endpackage

// File: rtl/mul4_popcount64.sv
// Combinational count of set bits across four 16-bit match words.
// Result range is 0..64.
module mul4_popcount64
  import mul4_tournament_pkg::*;
(
  input  logic [15:0]        m3,
  input  logic [15:0]        m2,
  input  logic [15:0]        m1,
  input  logic [15:0]        m0,
  output logic [SCORE_W-1:0] cnt
);

  logic [63:0] all;

  assign all = {m3, m2, m1, m0};

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + SCORE_W'(all[i]);
    end
  end

endmodule

// File: rtl/mul4_tournament_ctrl.sv
// Sweeps candidates through cand_sel, scores each against the
// golden 2x2 multiplier, and keeps the best index and score.
module mul4_tournament_ctrl
  import mul4_tournament_pkg::*;
#(
  parameter int NUM_CAND   = 8,
  parameter int SETTLE     = 2,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int IW = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [15:0]        a1,
  output logic [15:0]        a0,
  output logic [15:0]        b1,
  output logic [15:0]        b0,
  output logic [IW-1:0]      cand_sel,
  input  logic [15:0]        y3,
  input  logic [15:0]        y2,
  input  logic [15:0]        y1,
  input  logic [15:0]        y0,
  output logic               busy,
  output logic               done,
  output logic [IW-1:0]      best_idx,
  output logic [SCORE_W-1:0] best_score
);

  state_t              state;
  state_t              nxt;
  logic [IW-1:0]       idx;
  logic [3:0]          cnt;
  logic [15:0]         c3, c2, c1, c0;
  logic [SCORE_W-1:0]  score;
  logic                last;
  logic                perfect;

  assign a1 = VEC_A1;
  assign a0 = VEC_A0;
  assign b1 = VEC_B1;
  assign b0 = VEC_B0;

  assign cand_sel = idx;
  assign busy     = (state != IDLE);
  assign last     = (idx == IW'(NUM_CAND - 1));
  assign perfect  = (score == SCORE_W'(64));

  mul4_popcount64 u_pop (
    .m3  (~(c3 ^ GOLD_3)),
    .m2  (~(c2 ^ GOLD_2)),
    .m1  (~(c1 ^ GOLD_1)),
    .m0  (~(c0 ^ GOLD_0)),
    .cnt (score)
  );

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (start) nxt = SEL;
        SEL:   nxt = WAIT;
        WAIT:  if (cnt == 4'd0) nxt = SCORE;
        SCORE: begin
          if (last || (EARLY_EXIT && perfect))
            nxt = DONE;
          else
            nxt = SEL;
        end
        DONE:  nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      c3         <= '0;
      c2         <= '0;
      c1         <= '0;
      c0         <= '0;
      best_idx   <= '0;
      best_score <= '0;
      done       <= 1'b0;
    end else begin
      state <= nxt;
      done  <= (state == DONE) && !abort;
      if (!abort) begin
        unique case (state)
          IDLE: begin
            if (start) begin
              idx        <= '0;
              best_idx   <= '0;
              best_score <= '0;
            end
          end
          SEL: cnt <= 4'(SETTLE - 1);
          WAIT: begin
            if (cnt == 4'd0) begin
              c3 <= y3;
              c2 <= y2;
              c1 <= y1;
              c0 <= y0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          SCORE: begin
            // candidate 0 always loads; ties keep the lower index
            if (idx == '0 || score > best_score) begin
              best_score <= score;
              best_idx   <= idx;
            end
            if (nxt == SEL) idx <= idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul4_tournament_ctrl.sv
// Scoreboard bench for mul4_tournament_ctrl: candidate patterns,
// early exit, ties, abort, async reset, start while busy.
module tb_mul4_tournament_ctrl;

  localparam int NC = 8;
  localparam int ST = 2;
  localparam bit EE = 1'b1;

  typedef struct {
    int idx;
    int score;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] a1, a0, b1, b0;
  logic [2:0]  cand_sel;
  logic [15:0] y3, y2, y1, y0;
  logic        busy, done;
  logic [2:0]  best_idx;
  logic [6:0]  best_score;

  logic [63:0] gold;
  int          mode = 0;
  int          nchk = 0;
  int          nerr = 0;
  exp_t        q[$];

  always #5 clk = ~clk;

  mul4_tournament_ctrl #(
    .NUM_CAND   (NC),
    .SETTLE     (ST),
    .EARLY_EXIT (EE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .a1         (a1),
    .a0         (a0),
    .b1         (b1),
    .b0         (b0),
    .cand_sel   (cand_sel),
    .y3         (y3),
    .y2         (y2),
    .y1         (y1),
    .y0         (y0),
    .busy       (busy),
    .done       (done),
    .best_idx   (best_idx),
    .best_score (best_score)
  );

  function automatic logic [63:0] cand(int m, int s);
    logic [63:0] w;
    unique case (m)
      0: w = (s == 3) ? gold : 64'h0;
      1: w = (s == 5) ? 64'h0 : {64{1'b1}};
      2: w = 64'h0;
      default: begin
        w = {64{1'b1}};
        if (s == 6) begin
          w = gold;
          w[5] = ~w[5];
        end
      end
    endcase
    return w;
  endfunction

  function automatic int score_of(logic [63:0] w);
    int n = 0;
    for (int i = 0; i < 64; i++)
      if (w[i] == gold[i]) n++;
    return n;
  endfunction

  always_comb begin
    logic [63:0] w;
    w = cand(mode, int'(cand_sel));
    {y3, y2, y1, y0} = w;
  end

  task automatic chk(string tag, int act, int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic run_sweep(int m, bit poke);
    exp_t e;
    int   bs, bi, k, s, n;
    mode = m;
    bs = 0;
    bi = 0;
    k = NC - 1;
    for (int c = 0; c < NC; c++) begin
      s = score_of(cand(m, c));
      if (c == 0 || s > bs) begin
        bs = s;
        bi = c;
      end
      if (EE && s == 64) begin
        k = c;
        break;
      end
    end
    e.idx = bi;
    e.score = bs;
    e.cyc = (k + 1) * (ST + 2) + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      start = poke && (n == 5);
    end
    start = 1'b0;
    e = q.pop_front();
    if (!done) chk("done_timeout", 0, 1);
    chk("done_cycle", n, e.cyc);
    chk("best_idx", int'(best_idx), e.idx);
    chk("best_score", int'(best_score), e.score);
    @(posedge clk);
    #1;
    chk("done_pulse_one", int'(done), 0);
    chk("best_idx_held", int'(best_idx), e.idx);
  endtask

  initial begin
    logic [15:0] ea1, ea0, eb1, eb0;
    int p;
    for (int i = 0; i < 16; i++) begin
      p = (i >> 2) * (i & 3);
      for (int b = 0; b < 4; b++)
        gold[b * 16 + i] = p[b];
      ea1[i] = i[3];
      ea0[i] = i[2];
      eb1[i] = i[1];
      eb0[i] = i[0];
    end

    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sel", int'(cand_sel), 0);
    chk("rst_bidx", int'(best_idx), 0);
    chk("rst_bscore", int'(best_score), 0);
    chk("vec_a1", int'(a1), int'(ea1));
    chk("vec_a0", int'(a0), int'(ea0));
    chk("vec_b1", int'(b1), int'(eb1));
    chk("vec_b0", int'(b0), int'(eb0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_sweep(0, 1'b0);
    run_sweep(1, 1'b1);
    run_sweep(2, 1'b0);
    run_sweep(3, 1'b0);

    mode = 0;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", int'(busy), 0);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_sel", int'(cand_sel), 2);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_sel_kept", int'(cand_sel), 2);
    chk("abort_bscore", int'(best_score), 50);
    chk("abort_bidx", int'(best_idx), 0);
    p = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) p++;
    end
    chk("abort_no_done", p, 0);
    run_sweep(0, 1'b0);

    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_sel", int'(cand_sel), 0);
    chk("arst_bidx", int'(best_idx), 0);
    chk("arst_bscore", int'(best_score), 0);
    chk("arst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    p = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) p++;
    end
    chk("arst_quiet", p, 0);
    run_sweep(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
